// File: rtl/imode_arb_pkg.sv
// imode_arb_pkg: shared types and constants for the interface mode arbiter.
// State encoding, iface_mode codes, the scorer publish threshold and the
// early-exit edge threshold live here so the top and the bench agree on them.
package imode_arb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SE_SETTLE,
    SE_CLEAR,
    SE_MEASURE,
    SE_CAPTURE,
    DIFF_SETTLE,
    DIFF_CLEAR,
    DIFF_MEASURE,
    DIFF_CAPTURE,
    DECIDE,
    DONE
  } state_t;

  localparam logic [1:0] IMODE_UNKNOWN = 2'd0;
  localparam logic [1:0] IMODE_SE      = 2'd1;
  localparam logic [1:0] IMODE_DIFF    = 2'd2;

  // Below this many edges the scorer has not published a meaningful score.
  localparam logic [15:0] SCORE_MIN_EDGES  = 16'd128;
  // A measure window may end early once this many edges have been seen.
  localparam logic [15:0] EARLY_EXIT_EDGES = 16'd8192;

  // Force quality to zero when the scorer has not yet published a score.
  function automatic logic [7:0] gate_quality(input logic [7:0] q, input logic [15:0] edges);
    return (edges < SCORE_MIN_EDGES) ? 8'd0 : q;
  endfunction

endpackage

// File: rtl/imode_arb_timer.sv
// imode_arb_timer: loadable down-counter with a zero flag. Loading N-1 makes
// the owning state last exactly N cycles; the counter parks at zero.
module imode_arb_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/interface_mode_arbiter.sv
// interface_mode_arbiter: measures the SE and DIFF receiver paths in turn
// with the signal quality scorer and reports which electrical interface is
// present, plus the winning pass's bin and average width.
// Optional build macro: INTERFACE_MODE_ARBITER_EARLY_EXIT_EN -- a measure
// window also ends once the scorer edge count reaches EARLY_EXIT_EDGES.
module interface_mode_arbiter
  import imode_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3000,
  parameter int WINDOW_CYCLES = 3000000,
  parameter int MIN_EDGES     = 256,
  parameter int MIN_QUALITY   = 128,
  parameter int MARGIN        = 16,
  parameter int MAX_RETRIES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        rx_mode_diff,
  output logic        sq_enable,
  output logic        sq_clear,
  input  logic [7:0]  sq_quality,
  input  logic [15:0] sq_edge_count,
  input  logic [2:0]  sq_best_bin,
  input  logic [15:0] sq_avg_width,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic [1:0]  iface_mode,
  output logic [7:0]  se_quality,
  output logic [7:0]  diff_quality,
  output logic [2:0]  result_bin,
  output logic [15:0] result_avg_width,
  output logic [1:0]  retry_count
);

  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES - 1);

  state_t state_reg, state_next;

  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;
  logic             measure_end;

  logic [15:0] se_edges_reg, diff_edges_reg;
  logic [2:0]  se_bin_reg, diff_bin_reg;
  logic [15:0] se_width_reg, diff_width_reg;

  logic       rx_mode_diff_reg, sq_enable_reg, sq_clear_reg, busy_reg, done_reg;
  logic       result_valid_reg;
  logic [1:0] iface_mode_reg, retry_count_reg;
  logic [7:0] se_quality_reg, diff_quality_reg;
  logic [2:0] result_bin_reg;
  logic [15:0] result_avg_width_reg;

  logic       se_valid, diff_valid, se_higher, separated, se_wins, diff_wins;
  logic [8:0] quality_delta;

  imode_arb_timer #(.WIDTH(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

`ifdef INTERFACE_MODE_ARBITER_EARLY_EXIT_EN
  assign measure_end = timer_zero || (sq_edge_count >= EARLY_EXIT_EDGES);
`else
  assign measure_end = timer_zero;
`endif

  // Pass comparison on the captured (gated) values; delta carries one extra bit.
  assign se_valid      = (se_edges_reg >= 16'(MIN_EDGES)) && (se_quality_reg >= 8'(MIN_QUALITY));
  assign diff_valid    = (diff_edges_reg >= 16'(MIN_EDGES)) && (diff_quality_reg >= 8'(MIN_QUALITY));
  assign se_higher     = (se_quality_reg >= diff_quality_reg);
  assign quality_delta = se_higher ? ({1'b0, se_quality_reg} - {1'b0, diff_quality_reg})
                                   : ({1'b0, diff_quality_reg} - {1'b0, se_quality_reg});
  assign separated     = (quality_delta >= 9'(MARGIN));
  assign se_wins       = se_valid && (!diff_valid || (separated && se_higher));
  assign diff_wins     = diff_valid && (!se_valid || (separated && !se_higher));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and timer loads; abort overrides everything.
  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      IDLE: if (start) begin
        state_next  = SE_SETTLE;
        timer_load  = 1'b1;
        timer_value = SETTLE_LOAD;
      end
      SE_SETTLE:  if (timer_zero) state_next = SE_CLEAR;
      SE_CLEAR: begin
        state_next  = SE_MEASURE;
        timer_load  = 1'b1;
        timer_value = WINDOW_LOAD;
      end
      SE_MEASURE: if (measure_end) state_next = SE_CAPTURE;
      SE_CAPTURE: begin
        state_next  = DIFF_SETTLE;
        timer_load  = 1'b1;
        timer_value = SETTLE_LOAD;
      end
      DIFF_SETTLE: if (timer_zero) state_next = DIFF_CLEAR;
      DIFF_CLEAR: begin
        state_next  = DIFF_MEASURE;
        timer_load  = 1'b1;
        timer_value = WINDOW_LOAD;
      end
      DIFF_MEASURE: if (measure_end) state_next = DIFF_CAPTURE;
      DIFF_CAPTURE: state_next = DECIDE;
      DECIDE: begin
        if (se_wins || diff_wins || (retry_count_reg >= 2'(MAX_RETRIES))) begin
          state_next = DONE;
        end else begin
          state_next  = SE_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      timer_load = 1'b0;
    end
  end

  // Registered control outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_mode_diff_reg <= 1'b0;
      sq_enable_reg    <= 1'b0;
      sq_clear_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      sq_enable_reg <= (state_next == SE_MEASURE) || (state_next == DIFF_MEASURE);
      sq_clear_reg  <= (state_next == SE_CLEAR) || (state_next == DIFF_CLEAR);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
      case (state_next)
        SE_SETTLE, SE_CLEAR, SE_MEASURE, SE_CAPTURE:         rx_mode_diff_reg <= 1'b0;
        DIFF_SETTLE, DIFF_CLEAR, DIFF_MEASURE, DIFF_CAPTURE: rx_mode_diff_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  // Pass captures, decision results, retry count and result_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      se_quality_reg       <= '0;
      se_edges_reg         <= '0;
      se_bin_reg           <= '0;
      se_width_reg         <= '0;
      diff_quality_reg     <= '0;
      diff_edges_reg       <= '0;
      diff_bin_reg         <= '0;
      diff_width_reg       <= '0;
      iface_mode_reg       <= IMODE_UNKNOWN;
      result_bin_reg       <= '0;
      result_avg_width_reg <= '0;
      retry_count_reg      <= '0;
      result_valid_reg     <= 1'b0;
    end else if (abort) begin
      result_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          retry_count_reg  <= '0;
          result_valid_reg <= 1'b0;
        end
        SE_CAPTURE: begin
          se_quality_reg <= gate_quality(sq_quality, sq_edge_count);
          se_edges_reg   <= sq_edge_count;
          se_bin_reg     <= sq_best_bin;
          se_width_reg   <= sq_avg_width;
        end
        DIFF_CAPTURE: begin
          diff_quality_reg <= gate_quality(sq_quality, sq_edge_count);
          diff_edges_reg   <= sq_edge_count;
          diff_bin_reg     <= sq_best_bin;
          diff_width_reg   <= sq_avg_width;
        end
        DECIDE: begin
          if (se_wins) begin
            iface_mode_reg       <= IMODE_SE;
            result_bin_reg       <= se_bin_reg;
            result_avg_width_reg <= se_width_reg;
          end else if (diff_wins) begin
            iface_mode_reg       <= IMODE_DIFF;
            result_bin_reg       <= diff_bin_reg;
            result_avg_width_reg <= diff_width_reg;
          end else if (retry_count_reg < 2'(MAX_RETRIES)) begin
            retry_count_reg <= retry_count_reg + 2'd1;
          end else begin
            iface_mode_reg       <= IMODE_UNKNOWN;
            result_bin_reg       <= '0;
            result_avg_width_reg <= '0;
          end
        end
        DONE: result_valid_reg <= 1'b1;
        default: ;
      endcase
      if (state_next == DONE) begin
        result_valid_reg <= 1'b1;
      end
    end
  end

  assign rx_mode_diff     = rx_mode_diff_reg;
  assign sq_enable        = sq_enable_reg;
  assign sq_clear         = sq_clear_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign result_valid     = result_valid_reg;
  assign iface_mode       = iface_mode_reg;
  assign se_quality       = se_quality_reg;
  assign diff_quality     = diff_quality_reg;
  assign result_bin       = result_bin_reg;
  assign result_avg_width = result_avg_width_reg;
  assign retry_count      = retry_count_reg;

endmodule

// File: tb/tb_interface_mode_arbiter.sv
// tb_interface_mode_arbiter: directed scenarios with hand-computed
// expectations; a tiny scorer stand-in answers per receiver path.
module tb_interface_mode_arbiter;

  localparam int S        = 4;
  localparam int W        = 64;
  localparam int DONE_CYC = 2 * (S + W + 2) + 2;   // 142
  localparam int RETRY    = 2 * (S + W + 2) + 1;   // 141

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic rx_mode_diff, sq_enable, sq_clear, busy, done, result_valid;
  logic [7:0]  sq_quality, se_quality, diff_quality;
  logic [15:0] sq_edge_count, sq_avg_width, result_avg_width;
  logic [2:0]  sq_best_bin, result_bin;
  logic [1:0]  iface_mode, retry_count;

  // Scorer stand-in: fixed values per path, or an edge ramp per enable cycle.
  logic [7:0]  se_q = 8'd0, diff_q = 8'd0;
  logic [15:0] se_e = 16'd0, diff_e = 16'd0, se_w = 16'h1234, diff_w = 16'h0456;
  logic [2:0]  se_b = 3'd3, diff_b = 3'd6;
  logic        ramp_mode = 1'b0;
  logic [15:0] ramp_cnt = 16'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sq_clear) ramp_cnt <= 16'd0;
    else if (sq_enable) ramp_cnt <= ramp_cnt + 16'd1;
  end

  assign sq_quality    = rx_mode_diff ? diff_q : se_q;
  assign sq_edge_count = ramp_mode ? (ramp_cnt * 16'd440) : (rx_mode_diff ? diff_e : se_e);
  assign sq_best_bin   = rx_mode_diff ? diff_b : se_b;
  assign sq_avg_width  = rx_mode_diff ? diff_w : se_w;

  interface_mode_arbiter #(
    .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .MIN_EDGES(256),
    .MIN_QUALITY(128), .MARGIN(16), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rx_mode_diff(rx_mode_diff), .sq_enable(sq_enable), .sq_clear(sq_clear),
    .sq_quality(sq_quality), .sq_edge_count(sq_edge_count),
    .sq_best_bin(sq_best_bin), .sq_avg_width(sq_avg_width),
    .busy(busy), .done(done), .result_valid(result_valid),
    .iface_mode(iface_mode), .se_quality(se_quality), .diff_quality(diff_quality),
    .result_bin(result_bin), .result_avg_width(result_avg_width),
    .retry_count(retry_count)
  );

  // Pulse start, then step cycles until done (bounded). Cycle 1 is the first
  // cycle after the edge that sampled start. Optionally re-pulse start mid-run.
  task automatic run_to_done(input int extra_start_cyc, output int done_cyc);
    int cyc;
    done_cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= 1000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == extra_start_cyc);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic set_paths(input logic [7:0] sq, input logic [15:0] se, input logic [7:0] dq, input logic [15:0] de);
    se_q = sq; se_e = se; diff_q = dq; diff_e = de;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rx_mode_diff, sq_enable, sq_clear, busy, done, result_valid, iface_mode, se_quality,
         diff_quality, result_bin, result_avg_width, retry_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%0b rv=%0b mode=%0d seq=%0d diffq=%0d bin=%0d w=%0h rc=%0d required all 0",
               busy, result_valid, iface_mode, se_quality, diff_quality, result_bin, result_avg_width, retry_count);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_se_wins();
    int dc;
    set_paths(8'd200, 16'd1000, 8'd100, 16'd1000);
    run_to_done(0, dc);
    checks++;
    if (dc !== DONE_CYC) begin errors++; $display("FAIL se_done_cycle: got %0d required %0d", dc, DONE_CYC); end
    checks++;
    if (iface_mode !== 2'd1 || result_bin !== 3'd3 || result_avg_width !== 16'h1234) begin
      errors++; $display("FAIL se_result: mode=%0d bin=%0d w=%0h required 1/3/1234", iface_mode, result_bin, result_avg_width);
    end
    checks++;
    if (se_quality !== 8'd200 || diff_quality !== 8'd100 || result_valid !== 1'b1) begin
      errors++; $display("FAIL se_captures: seq=%0d diffq=%0d rv=%0b required 200/100/1", se_quality, diff_quality, result_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b1) begin
      errors++; $display("FAIL se_after_done: done=%0b busy=%0b rv=%0b required 0/0/1", done, busy, result_valid);
    end
    $display("test_se_wins: done at cycle %0d mode=%0d", dc, iface_mode);
  endtask

  task automatic test_diff_wins_start_ignored();
    int dc;
    set_paths(8'd170, 16'd50, 8'd180, 16'd900);
    run_to_done(10, dc);
    checks++;
    if (dc !== DONE_CYC) begin errors++; $display("FAIL diff_done_cycle: got %0d required %0d", dc, DONE_CYC); end
    checks++;
    if (iface_mode !== 2'd2 || se_quality !== 8'd0 || diff_quality !== 8'd180) begin
      errors++; $display("FAIL diff_result: mode=%0d seq=%0d diffq=%0d required 2/0/180", iface_mode, se_quality, diff_quality);
    end
    checks++;
    if (result_bin !== 3'd6 || result_avg_width !== 16'h0456) begin
      errors++; $display("FAIL diff_bin_width: bin=%0d w=%0h required 6/456", result_bin, result_avg_width);
    end
    @(posedge clk); #1;
    $display("test_diff_wins_start_ignored: done at cycle %0d mode=%0d", dc, iface_mode);
  endtask

  task automatic test_boundaries();
    int dc;
    // SE exactly at both minimums; DIFF one edge short of MIN_EDGES.
    set_paths(8'd128, 16'd256, 8'd250, 16'd255);
    run_to_done(0, dc);
    checks++;
    if (iface_mode !== 2'd1 || diff_quality !== 8'd250 || dc !== DONE_CYC) begin
      errors++; $display("FAIL min_edges_edge: mode=%0d diffq=%0d cyc=%0d required 1/250/%0d", iface_mode, diff_quality, dc, DONE_CYC);
    end
    @(posedge clk); #1;
    $display("test_boundaries: min-edges case mode=%0d", iface_mode);
    // Quality difference exactly MARGIN.
    set_paths(8'd150, 16'd1000, 8'd166, 16'd1000);
    run_to_done(0, dc);
    checks++;
    if (iface_mode !== 2'd2 || retry_count !== 2'd0 || dc !== DONE_CYC) begin
      errors++; $display("FAIL margin_edge: mode=%0d rc=%0d cyc=%0d required 2/0/%0d", iface_mode, retry_count, dc, DONE_CYC);
    end
    @(posedge clk); #1;
    $display("test_boundaries: margin case mode=%0d", iface_mode);
  endtask

  task automatic test_ambiguous();
    int dc;
    set_paths(8'd190, 16'd1000, 8'd200, 16'd1000);
    run_to_done(0, dc);
    checks++;
    if (dc !== DONE_CYC + 2 * RETRY) begin errors++; $display("FAIL amb_done_cycle: got %0d required %0d", dc, DONE_CYC + 2 * RETRY); end
    checks++;
    if (iface_mode !== 2'd0 || retry_count !== 2'd2 || result_bin !== 3'd0 || result_avg_width !== 16'd0) begin
      errors++; $display("FAIL amb_result: mode=%0d rc=%0d bin=%0d w=%0h required 0/2/0/0", iface_mode, retry_count, result_bin, result_avg_width);
    end
    checks++;
    if (result_valid !== 1'b1 || se_quality !== 8'd190 || diff_quality !== 8'd200) begin
      errors++; $display("FAIL amb_captures: rv=%0b seq=%0d diffq=%0d required 1/190/200", result_valid, se_quality, diff_quality);
    end
    @(posedge clk); #1;
    $display("test_ambiguous: done at cycle %0d retries=%0d", dc, retry_count);
  endtask

  task automatic test_abort();
    int dc;
    bit saw_done;
    set_paths(8'd200, 16'd1000, 8'd100, 16'd1000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 40; c++) begin @(posedge clk); #1; end
    checks++;
    if (sq_enable !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre: en=%0b busy=%0b required 1/1 at cycle 40", sq_enable, busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || sq_enable !== 1'b0 || sq_clear !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL abort_post: busy=%0b en=%0b clr=%0b rv=%0b required 0/0/0/0", busy, sq_enable, sq_clear, result_valid);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: saw_done=%0b busy=%0b required 0/0", saw_done, busy);
    end
    run_to_done(0, dc);
    checks++;
    if (dc !== DONE_CYC || iface_mode !== 2'd1) begin
      errors++; $display("FAIL abort_rerun: cyc=%0d mode=%0d required %0d/1", dc, iface_mode, DONE_CYC);
    end
    @(posedge clk); #1;
    $display("test_abort: rerun done at cycle %0d", dc);
  endtask

  task automatic test_reset_midrun();
    set_paths(8'd200, 16'd1000, 8'd100, 16'd1000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 110; c++) begin @(posedge clk); #1; end
    checks++;
    if (rx_mode_diff !== 1'b1 || sq_enable !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: diff=%0b en=%0b required 1/1", rx_mode_diff, sq_enable);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rx_mode_diff, sq_enable, sq_clear, busy, done, result_valid, iface_mode, se_quality,
         diff_quality, result_bin, result_avg_width, retry_count} !== '0) begin
      errors++;
      $display("FAIL reset_async: diff=%0b en=%0b busy=%0b mode=%0d seq=%0d bin=%0d w=%0h required all 0",
               rx_mode_diff, sq_enable, busy, iface_mode, se_quality, result_bin, result_avg_width);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    $display("test_reset_midrun: async reset checked");
  endtask

  task automatic test_early_exit();
    int en_cycles;
    int wait_cyc;
    int expected;
`ifdef INTERFACE_MODE_ARBITER_EARLY_EXIT_EN
    expected = 20;
`else
    expected = W;
`endif
    set_paths(8'd200, 16'd0, 8'd200, 16'd0);
    ramp_mode = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc = 0;
    while (!sq_enable && wait_cyc < 50) begin @(posedge clk); #1; wait_cyc++; end
    en_cycles = 0;
    while (sq_enable && en_cycles < 200) begin @(posedge clk); #1; en_cycles++; end
    checks++;
    if (en_cycles !== expected || wait_cyc >= 50) begin
      errors++; $display("FAIL measure_window: got %0d cycles required %0d", en_cycles, expected);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ramp_mode = 1'b0;
    $display("test_early_exit: SE window lasted %0d cycles", en_cycles);
  endtask

  initial begin
    test_reset();
    test_se_wins();
    test_diff_wins_start_ignored();
    test_boundaries();
    test_ambiguous();
    test_abort();
    test_reset_midrun();
    test_early_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interface_mode_arbiter.md
# interface_mode_arbiter

Phase 0 sequencer directly downstream of the signal quality scorer: it drives the receiver path select (single-ended vs differential), clears and enables the scorer for a fixed measurement window on each path, and captures the scorer results. It then compares the two passes and reports the detected electrical interface (SE for MFM/RLL, DIFF for ESDI) together with the winning pass's rate bin and average pulse width.

## Interface
Parameters:
- SETTLE_CYCLES, 3000: receiver settle time after a path switch (10 µs at 300 MHz).
- WINDOW_CYCLES, 3000000: measurement window per path (10 ms).
- MIN_EDGES, 256: minimum edge count for a pass to be valid.
- MIN_QUALITY, 128: minimum quality for a pass to be valid.
- MARGIN, 16: minimum quality difference that separates two valid passes.
- MAX_RETRIES, 2: maximum number of full SE+DIFF re-runs after an ambiguous result.

Ports:
- clk  in  1  300 MHz HDD-domain clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request; honoured only in IDLE.
- abort  in  1  return to IDLE; wins over every other input.
- rx_mode_diff  out  1  receiver path select: 0 = SE, 1 = DIFF.
- sq_enable  out  1  scorer enable.
- sq_clear  out  1  scorer clear.
- sq_quality  in  8  scorer quality.
- sq_edge_count  in  16  scorer edge count.
- sq_best_bin  in  3  scorer best histogram bin.
- sq_avg_width  in  16  scorer average pulse width.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- result_valid  out  1  level; set on done, cleared on start or abort.
- iface_mode  out  2  0 = unknown, 1 = SE, 2 = DIFF.
- se_quality, diff_quality  out  8 each  captured (gated) pass qualities.
- result_bin  out  3  best bin of the winning pass; 0 if unknown.
- result_avg_width  out  16  average width of the winning pass; 0 if unknown.
- retry_count  out  2  retries used in the last run.

## Operation
- States: IDLE, SE_SETTLE, SE_CLEAR, SE_MEASURE, SE_CAPTURE, DIFF_SETTLE, DIFF_CLEAR, DIFF_MEASURE, DIFF_CAPTURE, DECIDE, DONE.
- rx_mode_diff is 0 from SE_SETTLE through SE_CAPTURE and 1 from DIFF_SETTLE through DIFF_CAPTURE. It holds its value in DECIDE, DONE and IDLE.
- sq_clear is high only in the *_CLEAR states. sq_enable is high only in the *_MEASURE states.
- In the CAPTURE states the block latches quality, edge count, bin and width for that pass.
- Gated quality: if the captured edge count is below 128, quality is forced to 0, because the scorer has not yet published a score.
- A pass is valid when edges ≥ MIN_EDGES and gated quality ≥ MIN_QUALITY.
- DECIDE rules:
  - Exactly one pass valid: that pass wins.
  - Both valid and the quality difference ≥ MARGIN: the higher pass wins.
  - Both valid and the difference < MARGIN, or neither valid: ambiguous.
- On an ambiguous result:
  - If retries < MAX_RETRIES, increment retry_count and go to SE_SETTLE.
  - Otherwise iface_mode = 0 and go to DONE.
- DONE lasts 1 cycle: done pulses and result_valid sets. Next state is IDLE.
- start in IDLE clears retry_count and result_valid. start outside IDLE is ignored.
- abort in any state: next state is IDLE, sq_enable and sq_clear go low, result_valid clears, no done pulse, captured values are kept.
- Comparison is unsigned 9-bit (difference computed with one extra bit).

## Timing
- Reset values: rx_mode_diff 0, sq_enable 0, sq_clear 0, busy 0, done 0, result_valid 0, iface_mode 0, se_quality 0, diff_quality 0, result_bin 0, result_avg_width 0, retry_count 0.
- All outputs are registered.
- Let start be sampled in cycle 0. Then:
  - SE_SETTLE occupies cycles 1..S.
  - SE_CLEAR occupies cycle S+1.
  - SE_MEASURE occupies W cycles.
  - SE_CAPTURE occupies 1 cycle.
  - The DIFF pass repeats the same pattern.
  - DECIDE occurs at cycle 2(S+W+2)+1; done occurs at cycle 2(S+W+2)+2.
- Each retry adds 2(S+W+2)+1 cycles.
- Counters load N−1 and count down to 0, so each state lasts exactly N cycles; the counter width is $clog2(max(S,W)+1).
- The capture cycle sees the scorer values including edges from the final measure cycle.

## Configuration
- INTERFACE_MODE_ARBITER_EARLY_EXIT_EN, when defined: a MEASURE state also ends once sq_edge_count ≥ 8192. The following CAPTURE state timing is unchanged.
- Without the macro, every window runs the full WINDOW_CYCLES.

## Structure
- Package imode_arb_pkg holds:
  - the state enum;
  - the iface_mode codes IMODE_UNKNOWN / IMODE_SE / IMODE_DIFF;
  - the gating constant SCORE_MIN_EDGES = 128;
  - the early-exit threshold 8192.
- One sub-module, imode_arb_timer: a loadable down-counter with a zero flag, shared by the settle and measure states.

## Test plan
All scenarios use S=4, W=64, MIN_QUALITY=128, MARGIN=16.
- SE q=200 / e=1000, DIFF q=100 / e=1000 -> iface_mode=1, result_bin and result_avg_width taken from the SE capture, done at cycle 2(4+64+2)+2=142.
- SE e=50 (gated quality 0), DIFF q=180 / e=900 -> iface_mode=2, se_quality=0.
- SE q=190, DIFF q=200, both e=1000 -> two retries, then iface_mode=0 with retry_count=2, done at cycle 142+2·141=424.
- abort at cycle 40 during SE_MEASURE -> busy=0 and sq_enable=0 at the next cycle, no done, result_valid=0. A later start runs normally.
- reset asserted mid-DIFF_MEASURE -> every output returns to its reset value asynchronously. start ignored during busy: a start pulse at cycle 10 has no effect.
- With EARLY_EXIT_EN and sq_edge_count reaching 8192 at measure cycle 20 -> SE_CAPTURE follows on the next cycle. Without the macro the window stays at 64 cycles.
